// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Stall/flush/freeze control for a 5-stage ARM pipeline, with a
//               wait-state FSM for multi-cycle data-memory accesses and
//               saturating stall/flush performance counters. Optional macro
//               PIPELINE_HAZARD_FWD_EN restricts hazards to load-use only.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
  parameter int MEM_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1_ID,
  input  logic [3:0]       src2_ID,
  input  logic             twoSrc_ID,
  input  logic [3:0]       dest_EXE,
  input  logic             wbEn_EXE,
  input  logic             memRead_EXE,
  input  logic [3:0]       dest_MEM,
  input  logic             wbEn_MEM,
  input  logic             memReq_MEM,
  input  logic             branchTaken_EXE,
  output logic             freeze_PC,
  output logic             freeze_IF_Reg,
  output logic             flush_IF_Reg,
  output logic             freeze_ID_Reg,
  output logic             flush_ID_Reg,
  output logic             freeze_EXE_Reg,
  output logic             freeze_MEM_Reg,
  output logic             mem_ready,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] c_wait_load = (MEM_WAIT >= 2) ? 8'(MEM_WAIT - 2) : 8'd0;
  localparam bit         c_single    = (MEM_WAIT <= 1);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_wcnt, w_wcnt_nxt;
  logic             w_mem_ready;
  logic             w_mem_freeze;
  logic             w_match_exe;
  logic             w_match_mem;
  logic             w_hazard;
  logic             w_branch;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wcnt  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // mem_ready lands on the MEM_WAIT-th cycle of each access
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_mem_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (memReq_MEM) begin
          if (c_single) begin
            w_mem_ready = 1'b1;
          end else begin
            w_state_nxt = S_BUSY;
            w_wcnt_nxt  = c_wait_load;
          end
        end
      end
      S_BUSY: begin
        if (r_wcnt == 8'd0) begin
          w_mem_ready = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wcnt_nxt = r_wcnt - 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) w_mem_ready = 1'b0;
  end

  assign w_match_exe = wbEn_EXE & ((src1_ID == dest_EXE) | (twoSrc_ID & (src2_ID == dest_EXE)));
  assign w_match_mem = wbEn_MEM & ((src1_ID == dest_MEM) | (twoSrc_ID & (src2_ID == dest_MEM)));

`ifdef PIPELINE_HAZARD_FWD_EN
  // Forwarding covers everything except a load still in EXE
  assign w_hazard = ~rst & memRead_EXE & w_match_exe;
  logic w_unused_ok;
  assign w_unused_ok = w_match_mem;
`else
  assign w_hazard = ~rst & (w_match_exe | w_match_mem);
  logic w_unused_ok;
  assign w_unused_ok = memRead_EXE;
`endif

  assign w_mem_freeze = ~rst & memReq_MEM & ~w_mem_ready;
  assign w_branch     = ~rst & branchTaken_EXE;

  // Freeze beats branch beats hazard; a branch held across a freeze flushes on ready
  always_comb begin
    freeze_PC      = 1'b0;
    freeze_IF_Reg  = 1'b0;
    flush_IF_Reg   = 1'b0;
    freeze_ID_Reg  = 1'b0;
    flush_ID_Reg   = 1'b0;
    freeze_EXE_Reg = 1'b0;
    freeze_MEM_Reg = 1'b0;
    if (w_mem_freeze) begin
      freeze_PC      = 1'b1;
      freeze_IF_Reg  = 1'b1;
      freeze_ID_Reg  = 1'b1;
      freeze_EXE_Reg = 1'b1;
      freeze_MEM_Reg = 1'b1;
    end else if (w_branch) begin
      flush_IF_Reg = 1'b1;
      flush_ID_Reg = 1'b1;
    end else if (w_hazard) begin
      freeze_PC     = 1'b1;
      freeze_IF_Reg = 1'b1;
      flush_ID_Reg  = 1'b1;
    end
  end

  assign w_stall_inc = w_mem_freeze | (w_hazard & ~w_branch);
  assign w_flush_inc = w_branch & ~w_mem_freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign mem_ready    = w_mem_ready;
  assign stall_cycles = r_stall_cnt;
  assign flush_cycles = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Directed self-checking bench; default, MEM_WAIT=1 and CNT_W=4
//               instances share one stimulus bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

`ifdef PIPELINE_HAZARD_FWD_EN
  localparam bit c_fwd = 1'b1;
`else
  localparam bit c_fwd = 1'b0;
`endif

  // ctl = {freeze_PC, freeze_IF, flush_IF, freeze_ID, flush_ID, freeze_EXE, freeze_MEM, mem_ready}
  localparam logic [7:0] c_idle   = 8'b0000_0000;
  localparam logic [7:0] c_freeze = 8'b1101_0110;
  localparam logic [7:0] c_ready  = 8'b0000_0001;
  localparam logic [7:0] c_hazard = 8'b1100_1000;
  localparam logic [7:0] c_branch = 8'b0010_1000;
  localparam logic [7:0] c_br_rdy = 8'b0010_1001;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
  logic       twoSrc_ID, wbEn_EXE, memRead_EXE, wbEn_MEM, memReq_MEM, branchTaken_EXE;

  logic [7:0]  ctl, ctl_w1, ctl_c4;
  logic [15:0] stall_cycles, flush_cycles, stall_w1, flush_w1;
  logic [3:0]  stall_c4, flush_c4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MEM_WAIT(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .src1_ID(src1_ID), .src2_ID(src2_ID), .twoSrc_ID(twoSrc_ID),
    .dest_EXE(dest_EXE), .wbEn_EXE(wbEn_EXE), .memRead_EXE(memRead_EXE),
    .dest_MEM(dest_MEM), .wbEn_MEM(wbEn_MEM), .memReq_MEM(memReq_MEM),
    .branchTaken_EXE(branchTaken_EXE),
    .freeze_PC(ctl[7]), .freeze_IF_Reg(ctl[6]), .flush_IF_Reg(ctl[5]), .freeze_ID_Reg(ctl[4]),
    .flush_ID_Reg(ctl[3]), .freeze_EXE_Reg(ctl[2]), .freeze_MEM_Reg(ctl[1]), .mem_ready(ctl[0]),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles));

  pipeline_hazard_controller #(.MEM_WAIT(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst(rst), .src1_ID(src1_ID), .src2_ID(src2_ID), .twoSrc_ID(twoSrc_ID),
    .dest_EXE(dest_EXE), .wbEn_EXE(wbEn_EXE), .memRead_EXE(memRead_EXE),
    .dest_MEM(dest_MEM), .wbEn_MEM(wbEn_MEM), .memReq_MEM(memReq_MEM),
    .branchTaken_EXE(branchTaken_EXE),
    .freeze_PC(ctl_w1[7]), .freeze_IF_Reg(ctl_w1[6]), .flush_IF_Reg(ctl_w1[5]), .freeze_ID_Reg(ctl_w1[4]),
    .flush_ID_Reg(ctl_w1[3]), .freeze_EXE_Reg(ctl_w1[2]), .freeze_MEM_Reg(ctl_w1[1]), .mem_ready(ctl_w1[0]),
    .stall_cycles(stall_w1), .flush_cycles(flush_w1));

  pipeline_hazard_controller #(.MEM_WAIT(4), .CNT_W(4)) u_c4 (
    .clk(clk), .rst(rst), .src1_ID(src1_ID), .src2_ID(src2_ID), .twoSrc_ID(twoSrc_ID),
    .dest_EXE(dest_EXE), .wbEn_EXE(wbEn_EXE), .memRead_EXE(memRead_EXE),
    .dest_MEM(dest_MEM), .wbEn_MEM(wbEn_MEM), .memReq_MEM(memReq_MEM),
    .branchTaken_EXE(branchTaken_EXE),
    .freeze_PC(ctl_c4[7]), .freeze_IF_Reg(ctl_c4[6]), .flush_IF_Reg(ctl_c4[5]), .freeze_ID_Reg(ctl_c4[4]),
    .flush_ID_Reg(ctl_c4[3]), .freeze_EXE_Reg(ctl_c4[2]), .freeze_MEM_Reg(ctl_c4[1]), .mem_ready(ctl_c4[0]),
    .stall_cycles(stall_c4), .flush_cycles(flush_c4));

  task automatic clear_inputs;
    src1_ID = 4'd0; src2_ID = 4'd0; twoSrc_ID = 1'b0;
    dest_EXE = 4'd0; wbEn_EXE = 1'b0; memRead_EXE = 1'b0;
    dest_MEM = 4'd0; wbEn_MEM = 1'b0; memReq_MEM = 1'b0; branchTaken_EXE = 1'b0;
  endtask

  // Advance to just after the next rising edge; inputs change here, checks at negedge
  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    next_cycle();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    memReq_MEM = 1'b1; branchTaken_EXE = 1'b1;
    src1_ID = 4'd3; dest_EXE = 4'd3; wbEn_EXE = 1'b1; memRead_EXE = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++; if (ctl !== c_idle) begin errors++; $display("FAIL reset_ctl got %b expected %b", ctl, c_idle); end
    checks++; if (ctl_w1 !== c_idle) begin errors++; $display("FAIL reset_ctl_w1 got %b expected %b", ctl_w1, c_idle); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d expected 0", stall_cycles); end
    checks++; if (flush_cycles !== 16'd0) begin errors++; $display("FAIL reset_flush got %0d expected 0", flush_cycles); end
    next_cycle();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_mem_wait;
    do_reset();
    memReq_MEM = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (ctl !== ((c == 4) ? c_ready : c_freeze)) begin
        errors++; $display("FAIL mem_wait_cycle%0d got %b expected %b", c, ctl, (c == 4) ? c_ready : c_freeze);
      end
      if (c == 1) begin
        checks++; if (ctl_w1 !== c_ready) begin errors++; $display("FAIL mem_wait1_ready got %b expected %b", ctl_w1, c_ready); end
      end
      next_cycle();
    end
    memReq_MEM = 1'b0;
    @(negedge clk);
    checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL mem_wait_stall got %0d expected 3", stall_cycles); end
    checks++; if (stall_w1 !== 16'd0) begin errors++; $display("FAIL mem_wait1_stall got %0d expected 0", stall_w1); end
    // Fresh request must again take the full four cycles, proving IDLE was reached
    next_cycle();
    memReq_MEM = 1'b1;
    @(negedge clk);
    checks++; if (ctl !== c_freeze) begin errors++; $display("FAIL mem_idle_again got %b expected %b", ctl, c_freeze); end
    next_cycle(); next_cycle(); next_cycle();
    memReq_MEM = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_reset();
    memReq_MEM = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if (ctl !== ((c % 4 == 0) ? c_ready : c_freeze)) begin
        errors++; $display("FAIL b2b_cycle%0d got %b expected %b", c, ctl, (c % 4 == 0) ? c_ready : c_freeze);
      end
      next_cycle();
    end
    memReq_MEM = 1'b0;
    @(negedge clk);
    checks++; if (stall_cycles !== 16'd6) begin errors++; $display("FAIL b2b_stall got %0d expected 6", stall_cycles); end
  endtask

  task automatic test_hazard;
    do_reset();
    src1_ID = 4'd3; dest_EXE = 4'd3; wbEn_EXE = 1'b1; memRead_EXE = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== (c_fwd ? c_idle : c_hazard)) begin
      errors++; $display("FAIL hazard_exe got %b expected %b", ctl, c_fwd ? c_idle : c_hazard);
    end
    memRead_EXE = 1'b1;
    #1;
    checks++; if (ctl !== c_hazard) begin errors++; $display("FAIL hazard_load_use got %b expected %b", ctl, c_hazard); end
    clear_inputs();
  endtask

  task automatic test_two_src;
    do_reset();
    src1_ID = 4'd0; src2_ID = 4'd5; dest_MEM = 4'd5; wbEn_MEM = 1'b1; twoSrc_ID = 1'b0;
    @(negedge clk);
    checks++; if (ctl !== c_idle) begin errors++; $display("FAIL two_src_off got %b expected %b", ctl, c_idle); end
    twoSrc_ID = 1'b1;
    #1;
    checks++;
    if (ctl !== (c_fwd ? c_idle : c_hazard)) begin
      errors++; $display("FAIL two_src_on got %b expected %b", ctl, c_fwd ? c_idle : c_hazard);
    end
    clear_inputs();
  endtask

  task automatic test_branch;
    do_reset();
    src1_ID = 4'd3; dest_EXE = 4'd3; wbEn_EXE = 1'b1; branchTaken_EXE = 1'b1;
    @(negedge clk);
    checks++; if (ctl !== c_branch) begin errors++; $display("FAIL branch_ctl got %b expected %b", ctl, c_branch); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (flush_cycles !== 16'd1) begin errors++; $display("FAIL branch_flush_cnt got %0d expected 1", flush_cycles); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL branch_stall_cnt got %0d expected 0", stall_cycles); end
  endtask

  task automatic test_branch_in_mem;
    do_reset();
    memReq_MEM = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) branchTaken_EXE = 1'b1;
      #1;
      @(negedge clk);
      checks++;
      if (ctl !== ((c == 4) ? c_br_rdy : c_freeze)) begin
        errors++; $display("FAIL br_mem_cycle%0d got %b expected %b", c, ctl, (c == 4) ? c_br_rdy : c_freeze);
      end
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    checks++; if (flush_cycles !== 16'd1) begin errors++; $display("FAIL br_mem_flush_cnt got %0d expected 1", flush_cycles); end
    checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL br_mem_stall_cnt got %0d expected 3", stall_cycles); end
  endtask

  task automatic test_reset_mid_access;
    do_reset();
    memReq_MEM = 1'b1;
    next_cycle(); next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ctl !== c_idle) begin errors++; $display("FAIL mid_rst_ctl got %b expected %b", ctl, c_idle); end
    next_cycle();
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL mid_rst_stall got %0d expected 0", stall_cycles); end
      end
      checks++;
      if (ctl !== ((c == 4) ? c_ready : c_freeze)) begin
        errors++; $display("FAIL mid_rst_cycle%0d got %b expected %b", c, ctl, (c == 4) ? c_ready : c_freeze);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_saturation;
    do_reset();
    src1_ID = 4'd3; dest_EXE = 4'd3; wbEn_EXE = 1'b1; memRead_EXE = 1'b1;
    for (int c = 0; c < 20; c++) next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (stall_c4 !== 4'd15) begin errors++; $display("FAIL sat_stall_c4 got %0d expected 15", stall_c4); end
    checks++; if (stall_cycles !== 16'd20) begin errors++; $display("FAIL sat_stall_c16 got %0d expected 20", stall_cycles); end
    checks++; if (flush_c4 !== 4'd0) begin errors++; $display("FAIL sat_flush_c4 got %0d expected 0", flush_c4); end
  endtask

  initial begin
    test_reset();
    test_mem_wait();
    test_back_to_back();
    test_hazard();
    test_two_src();
    test_branch();
    test_branch_in_mem();
    test_reset_mid_access();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
